// File: rtl/alu_mc_pkg.sv
// -----------------------------------------------------------------------------
// alu_mc_pkg
// Shared definitions for the multi-cycle EX-stage ALU (alu_mc):
//   - 4-bit opcode encodings
//   - FSM state type (IDLE / CALC / DONE)
//   - helpers that classify an opcode as iterative (multi-cycle) or divide
// Optional feature macro: ALU_MC_DIV_EN (enables DIVU/REMU as iterative ops).
// -----------------------------------------------------------------------------
package alu_mc_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_COMP = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0110;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1010;
    localparam logic [3:0] OP_REMU = 4'b1011;
    localparam logic [3:0] OP_SLLV = 4'b1100;
    localparam logic [3:0] OP_SRLV = 4'b1101;
    localparam logic [3:0] OP_SRAV = 4'b1110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // True for opcodes that run through the WIDTH-step iterative unit.
    function automatic logic op_is_iter(input logic [3:0] op);
`ifdef ALU_MC_DIV_EN
        return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
`else
        return (op == OP_MULU);
`endif
    endfunction

    // True for the divider opcodes (only meaningful when the divider exists).
    function automatic logic op_is_div(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// -----------------------------------------------------------------------------
// alu_mc_iter
// WIDTH-step iterative unit: unsigned shift-add multiplier and (optionally)
// unsigned restoring divider, sharing one 2*WIDTH working register.
//
// Optional feature macro: ALU_MC_DIV_EN (divider half present when defined).
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   start  in   load operands and perform the first iteration this edge
//   op     in   opcode (MULU, or DIVU/REMU when the divider is built)
//   a, b   in   operands (unsigned)
//   busy   out  high while the remaining WIDTH-1 iterations run
//   result out  low product / quotient / remainder
//   flag   out  product overflow (high half nonzero) or divide-by-zero
//
// Timing: the first iteration happens on the start edge itself, the remaining
// WIDTH-1 on the following busy cycles; result/flag are valid once busy drops
// and stay valid until the next start.
// -----------------------------------------------------------------------------
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             flag
);

    // Working register layout:
    //   multiply: {partial-product high half, multiplier bits not yet consumed}
    //   divide  : {partial remainder, dividend bits shifting into quotient}
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_opnd;     // multiplicand (mul) or divisor (div)
    logic [SHW-1:0]     r_cnt;
    logic               r_busy;

    logic               w_load;
    logic [2*WIDTH-1:0] w_p_cur;
    logic [WIDTH-1:0]   w_opnd_cur;
    logic [2*WIDTH-1:0] w_p_next;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_load = start && op_is_iter(op);

`ifdef ALU_MC_DIV_EN
    logic               r_div;
    logic               r_rem;
    logic               r_bzero;
    logic               w_div_cur;
    logic [WIDTH:0]     w_rsh;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_div_next;
`endif

    // The step operates either on freshly loaded operands (start edge) or on
    // the registered state, so the first iteration costs no extra cycle.
    always_comb begin
        w_p_cur    = r_p;
        w_opnd_cur = r_opnd;
`ifdef ALU_MC_DIV_EN
        w_div_cur  = r_div;
`endif
        if (w_load) begin
            w_p_cur    = {{WIDTH{1'b0}}, b};
            w_opnd_cur = a;
`ifdef ALU_MC_DIV_EN
            w_div_cur  = op_is_div(op);
            if (op_is_div(op)) begin
                w_p_cur    = {{WIDTH{1'b0}}, a};
                w_opnd_cur = b;
            end
`endif
        end
    end

    // Shift-add: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole register right by one.
    assign w_sum      = {1'b0, w_p_cur[2*WIDTH-1:WIDTH]}
                      + (w_p_cur[0] ? {1'b0, w_opnd_cur} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_sum, w_p_cur[WIDTH-1:1]};

`ifdef ALU_MC_DIV_EN
    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. With a zero divisor every step
    // "fits", which naturally yields quotient all ones and remainder = A.
    assign w_rsh      = {w_p_cur[2*WIDTH-1:WIDTH], w_p_cur[WIDTH-1]};
    assign w_diff     = w_rsh - {1'b0, w_opnd_cur};
    assign w_qbit     = ~w_diff[WIDTH];
    assign w_div_next = {(w_qbit ? w_diff[WIDTH-1:0] : w_rsh[WIDTH-1:0]),
                         w_p_cur[WIDTH-2:0], w_qbit};
    assign w_p_next   = w_div_cur ? w_div_next : w_mul_next;
`else
    assign w_p_next   = w_mul_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p    <= '0;
            r_opnd <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
`ifdef ALU_MC_DIV_EN
            r_div   <= 1'b0;
            r_rem   <= 1'b0;
            r_bzero <= 1'b0;
`endif
        end else if (w_load) begin
            r_p    <= w_p_next;
            r_opnd <= w_opnd_cur;
            r_cnt  <= SHW'(WIDTH - 1);
            r_busy <= 1'b1;
`ifdef ALU_MC_DIV_EN
            r_div   <= op_is_div(op);
            r_rem   <= (op == OP_REMU);
            r_bzero <= (b == '0);
`endif
        end else if (r_busy) begin
            r_p   <= w_p_next;
            r_cnt <= r_cnt - SHW'(1);
            if (r_cnt == SHW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy = r_busy;

`ifdef ALU_MC_DIV_EN
    assign result = r_rem ? r_p[2*WIDTH-1:WIDTH] : r_p[WIDTH-1:0];
    assign flag   = r_div ? r_bzero : (|r_p[2*WIDTH-1:WIDTH]);
`else
    assign result = r_p[WIDTH-1:0];
    assign flag   = |r_p[2*WIDTH-1:WIDTH];
`endif

endmodule

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc
// Multi-cycle EX-stage ALU with valid/ready handshakes on input and output.
// Single-cycle ops (add, negate, and, xor, shifts) finish one cycle after
// accept; MULU (and DIVU/REMU when built) run WIDTH iterations in alu_mc_iter.
//
// Optional feature macro: ALU_MC_DIV_EN (DIVU/REMU; illegal opcodes otherwise).
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operand/op offer
//   in_ready   out  can accept (IDLE only)
//   input1     in   operand A
//   input2     in   operand B; low SHW bits are the variable shift amount
//   shamt      in   immediate shift amount
//   control    in   4-bit opcode
//   out_valid  out  result available (DONE)
//   out_ready  in   consumer takes the result
//   out        out  registered result
//   flag       out  registered status bit
// -----------------------------------------------------------------------------
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [SHW-1:0]   shamt,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             flag
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_out;
    logic             r_flag;

    logic             w_accept;
    logic             w_is_iter;
    logic             w_start;
    logic             w_iter_busy;
    logic [WIDTH-1:0] w_iter_result;
    logic             w_iter_flag;

    logic [WIDTH-1:0] w_sc_result;
    logic             w_sc_flag;
    logic [SHW-1:0]   w_amt;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_srl;
    logic [WIDTH:0]   w_sra;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_is_iter = op_is_iter(control);
    assign w_start   = w_accept && w_is_iter;

    // ---------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live inputs and captured
    // on the accept edge.
    // ---------------------------------------------------------------
    assign w_amt = control[3] ? input2[SHW-1:0] : shamt;
    assign w_add = {1'b0, input1} + {1'b0, input2};

    // Each shift is done one bit wider so the last bit shifted out lands in
    // the extra position; with amount 0 that position holds the padding 0.
    assign w_shl = {1'b0, input1} << w_amt;
    assign w_srl = {input1, 1'b0} >> w_amt;
    assign w_sra = $signed({input1, 1'b0}) >>> w_amt;

    always_comb begin
        w_sc_result = '0;
        w_sc_flag   = 1'b1;
        case (control)
            OP_ADD: begin
                w_sc_result = w_add[WIDTH-1:0];
                w_sc_flag   = w_add[WIDTH];
            end
            OP_COMP: begin
                w_sc_result = {WIDTH{1'b0}} - input2;
                w_sc_flag   = (input2 == {1'b1, {(WIDTH-1){1'b0}}});
            end
            OP_AND: begin
                w_sc_result = input1 & input2;
                w_sc_flag   = 1'b0;
            end
            OP_XOR: begin
                w_sc_result = input1 ^ input2;
                w_sc_flag   = 1'b0;
            end
            OP_SLL, OP_SLLV: begin
                w_sc_result = w_shl[WIDTH-1:0];
                w_sc_flag   = w_shl[WIDTH];
            end
            OP_SRL, OP_SRLV: begin
                w_sc_result = w_srl[WIDTH:1];
                w_sc_flag   = w_srl[0];
            end
            OP_SRA, OP_SRAV: begin
                w_sc_result = w_sra[WIDTH:1];
                w_sc_flag   = w_sra[0];
            end
            // Iterative opcodes never take this path when their unit exists;
            // without the divider DIVU/REMU land here as illegal ops.
            OP_MULU, OP_DIVU, OP_REMU: begin
                w_sc_result = '0;
                w_sc_flag   = 1'b1;
            end
            default: begin
                w_sc_result = '0;
                w_sc_flag   = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Iterative unit
    // ---------------------------------------------------------------
    alu_mc_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (w_start),
        .op     (control),
        .a      (input1),
        .b      (input2),
        .busy   (w_iter_busy),
        .result (w_iter_result),
        .flag   (w_iter_flag)
    );

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_state_next = w_is_iter ? CALC : DONE;
                end
            end
            CALC: begin
                // The unit's busy is registered, so it is already high on the
                // first CALC cycle and drops after the WIDTH-th iteration.
                if (!w_iter_busy) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_out   <= '0;
            r_flag  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept && !w_is_iter) begin
                r_out  <= w_sc_result;
                r_flag <= w_sc_flag;
            end else if ((r_state == CALC) && !w_iter_busy) begin
                r_out  <= w_iter_result;
                r_flag <= w_iter_flag;
            end
        end
    end

    assign out  = r_out;
    assign flag = r_flag;

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc
// Directed self-checking bench for alu_mc (WIDTH=32). Expected values are
// hand-computed constants. Divider vectors are selected by ALU_MC_DIV_EN.
// -----------------------------------------------------------------------------
module tb_alu_mc;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] input1;
    logic [31:0] input2;
    logic [4:0]  shamt;
    logic [3:0]  control;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        flag;

    int n_cmp;
    int n_fail;

    alu_mc #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input1    (input1),
        .input2    (input2),
        .shamt     (shamt),
        .control   (control),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flag      (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Offer one op, wait (bounded) for out_valid, check result, then drain it.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input logic [3:0] ctl,
                          input logic [31:0] exp_out, input logic exp_flag, input int exp_lat);
        int   lat;
        logic rdy_seen;
        @(negedge clk);
        input1   = a;
        input2   = b;
        shamt    = sh;
        control  = ctl;
        in_valid = 1'b1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble inputs after accept: the DUT must use the latched values.
        input1   = $urandom;
        input2   = $urandom;
        shamt    = 5'($urandom);
        control  = 4'($urandom);
        lat      = 0;
        rdy_seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (in_ready) rdy_seen = 1'b1;
        end while (!out_valid && lat < 100);
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".out"}, out, exp_out);
        check({tag, ".flag"}, 32'(flag), 32'(exp_flag));
        check({tag, ".busy_no_ready"}, 32'(rdy_seen), 32'd0);
        $display("op %-8s ctl=%b a=%08h b=%08h sh=%0d -> out=%08h flag=%b lat=%0d",
                 tag, ctl, a, b, sh, out, flag, lat);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] held_out;
        logic        held_flag;
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        input1    = '0;
        input2    = '0;
        shamt     = '0;
        control   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out", out, 32'd0);
        check("reset.flag", 32'(flag), 32'd0);

        // ADD
        run_op("add_a", 32'd2147483647, 32'd106, 5'd0, 4'b0000, 32'h8000_0069, 1'b0, 1);
        run_op("add_c", 32'h8000_0000, 32'h8000_0000, 5'd0, 4'b0000, 32'h0000_0000, 1'b1, 1);
        // COMP / AND / XOR
        run_op("comp", 32'h1234_5678, 32'd5, 5'd0, 4'b0001, 32'hFFFF_FFFB, 1'b0, 1);
        run_op("comp_mn", 32'd0, 32'h8000_0000, 5'd0, 4'b0001, 32'h8000_0000, 1'b1, 1);
        run_op("and", 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 4'b0010, 32'h00F0_1200, 1'b0, 1);
        run_op("xor", 32'hAAAA_5555, 32'hFFFF_0000, 5'd0, 4'b0011, 32'h5555_5555, 1'b0, 1);
        // Shifts
        run_op("srav", 32'hFFFF_FF89, 32'd3, 5'd0, 4'b1110, 32'hFFFF_FFF1, 1'b0, 1);
        run_op("sll", 32'd259, 32'd0, 5'd4, 4'b0100, 32'd4144, 1'b0, 1);
        run_op("srl0", 32'd119, 32'd0, 5'd0, 4'b0101, 32'd119, 1'b0, 1);
        run_op("sll_f", 32'h8000_0001, 32'd0, 5'd1, 4'b0100, 32'h0000_0002, 1'b1, 1);
        run_op("srlv_f", 32'h0000_00F0, 32'hFFFF_FFE5, 5'd0, 4'b1101, 32'h0000_0007, 1'b1, 1);
        run_op("sra31", 32'h8000_0000, 32'd0, 5'd31, 4'b0110, 32'hFFFF_FFFF, 1'b0, 1);
        // Illegal opcode
        run_op("illegal", 32'd7, 32'd9, 5'd0, 4'b0111, 32'd0, 1'b1, 1);
        // MULU
        run_op("mulu", 32'd1234, 32'd5678, 5'd0, 4'b1000, 32'd7006652, 1'b0, 33);
        run_op("mulu_ov", 32'h0001_0000, 32'h0001_0000, 5'd0, 4'b1000, 32'd0, 1'b1, 33);
        run_op("mulu_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 4'b1000, 32'd1, 1'b1, 33);
        // DIVU / REMU
`ifdef ALU_MC_DIV_EN
        run_op("divu", 32'd100, 32'd7, 5'd0, 4'b1010, 32'd14, 1'b0, 33);
        run_op("remu", 32'd100, 32'd7, 5'd0, 4'b1011, 32'd2, 1'b0, 33);
        run_op("divu_z", 32'd100, 32'd0, 5'd0, 4'b1010, 32'hFFFF_FFFF, 1'b1, 33);
        run_op("remu_z", 32'd100, 32'd0, 5'd0, 4'b1011, 32'd100, 1'b1, 33);
`else
        run_op("divu_il", 32'd100, 32'd7, 5'd0, 4'b1010, 32'd0, 1'b1, 1);
        run_op("remu_il", 32'd100, 32'd7, 5'd0, 4'b1011, 32'd0, 1'b1, 1);
`endif

        // Back-pressure: result held while in_valid offers a new op
        @(negedge clk);
        input1   = 32'd10;
        input2   = 32'd3;
        shamt    = 5'd0;
        control  = 4'b0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        input1  = 32'hF0F0_F0F0;
        input2  = 32'h0FF0_0FF0;
        control = 4'b0011;
        held_out  = 32'd13;
        held_flag = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.out_valid", 32'(out_valid), 32'd1);
            check("bp.out", out, held_out);
            check("bp.flag", 32'(flag), 32'(held_flag));
            check("bp.in_ready", 32'(in_ready), 32'd0);
        end
        $display("op bp_add   held out=%08h flag=%b for 5 cycles", out, flag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp.idle_valid", 32'(out_valid), 32'd0);
        check("bp.idle_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp.next_valid", 32'(out_valid), 32'd1);
        check("bp.next_out", out, 32'hFF00_FF00);
        check("bp.next_flag", 32'(flag), 32'd0);
        $display("op bp_xor   out=%08h flag=%b", out, flag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Leave a nonzero result/flag behind before the reset test
        run_op("mulu_pre", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 4'b1000, 32'd1, 1'b1, 33);

        // Reset on the 10th CALC cycle of a MULU
        @(negedge clk);
        input1   = 32'd1234;
        input2   = 32'd5678;
        control  = 4'b1000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("rst.mid_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out", out, 32'd0);
        check("rst.flag", 32'(flag), 32'd0);
        $display("op rst_mid  out_valid=%b in_ready=%b out=%08h flag=%b", out_valid, in_ready, out, flag);
        // No stray result may appear later from the aborted multiply
        repeat (30) @(negedge clk);
        check("rst.no_stray", 32'(out_valid), 32'd0);
        run_op("add_post", 32'd105, 32'd106, 5'd0, 4'b0000, 32'd211, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle successor to the KGP-RISC single-cycle ALU, sitting in the EX stage.
- Keeps the existing opcode set: add, complement, and, xor, and logical/arithmetic shifts by shamt or by register.
- Adds an iterative unsigned multiply and an optional iterative divide/remainder.
- Uses valid/ready handshakes on both input and output so the core can stall on long operations.

Parameters:
- WIDTH, 32: datapath width; must be a power of two and at least 8.
- SHW, $clog2(WIDTH): shift-amount width; derived, never overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/op offer.
- in_ready  out  1  block can accept; high only in IDLE.
- input1  in  WIDTH  operand A (signed).
- input2  in  WIDTH  operand B (signed); low SHW bits give the variable shift amount.
- shamt  in  SHW  immediate shift amount.
- control  in  4  opcode.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out  out  WIDTH  registered result.
- flag  out  1  registered status bit.

Behaviour:
- Reset values: out=0, flag=0, out_valid=0, in_ready=1, state=IDLE.
- Reset mid-operation aborts it; no result is produced.
- FSM states: IDLE, CALC, DONE.
  - Accept happens on an edge where in_valid && in_ready. The block latches input1, input2, shamt and control; later input changes are ignored.
  - IDLE goes to DONE for single-cycle ops. out_valid is high the cycle after accept (latency 1).
  - IDLE goes to CALC for MUL/DIV/REM. CALC runs exactly WIDTH iterations, then goes to DONE. out_valid rises WIDTH+1 cycles after accept.
  - DONE holds out, flag and out_valid stable until out_ready is high. On that edge the FSM returns to IDLE.
  - No accept is possible in DONE, so back-to-back throughput for single-cycle ops is one op every 2 cycles.
- Opcodes and flags:
  - 0000 ADD: out=A+B; flag=carry-out of bit WIDTH-1.
  - 0001 COMP: out=-B (two's complement); flag=1 iff B is the most negative value.
  - 0010 AND: flag=0.
  - 0011 XOR: flag=0.
  - 0100 SLL by shamt; 1100 SLL by B[SHW-1:0].
  - 0101 SRL by shamt; 1101 SRL by B[SHW-1:0].
  - 0110 SRA by shamt; 1110 SRA by B[SHW-1:0].
  - All shifts: flag=last bit shifted out, or 0 if the amount is 0.
  - 1000 MULU: shift-add, one partial product per cycle. out=low WIDTH bits of A*B (unsigned); flag=1 iff the high WIDTH bits are nonzero.
  - 1010 DIVU: restoring divide, one quotient bit per cycle; out=quotient.
  - 1011 REMU: same divider; out=remainder.
  - Divide by zero (DIVU/REMU): quotient all ones, remainder=A, flag=1. Otherwise flag=0.
  - Any other opcode: single-cycle, out=0, flag=1.
- Arithmetic wraps modulo 2^WIDTH. Shift amounts are always less than WIDTH by construction.

Optional Feature:
- Macro ALU_MC_DIV_EN.
- Defined: DIVU/REMU are implemented as above.
- Undefined: the divider logic is absent. 1010 and 1011 are treated as illegal opcodes (single-cycle, out=0, flag=1).
- MULU is always present.

Decomposition:
- Package alu_mc_pkg holds:
  - opcode localparams: OP_ADD, OP_COMP, OP_AND, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_MULU, OP_DIVU, OP_REMU;
  - the state enum IDLE/CALC/DONE.
- One sub-module, alu_mc_iter: the WIDTH-step shift-add multiplier and restoring divider.
  - Interface: start, op, A, B in; busy, result, flag out.
  - The divider half is guarded by ALU_MC_DIV_EN.
- Single-cycle ops and the FSM live in the top module.

Test Plan (WIDTH=32):
1. ADD:
   - A=2147483647, B=106 → out=0x80000069, flag=0, out_valid one cycle after accept.
   - A=B=0x80000000 → out=0, flag=1.
2. Shifts:
   - SRAV with A=-119, B=3 → out=-15 (0xFFFFFFF1), flag=0.
   - SLL with A=259, shamt=4 → out=4144, flag=0.
   - SRL with A=119, shamt=0 → out=119, flag=0.
3. MULU:
   - 1234×5678 → out=7006652, flag=0, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
   - 0x10000×0x10000 → out=0, flag=1.
4. DIVU/REMU with ALU_MC_DIV_EN defined:
   - 100/7 → 14; 100%7 → 2; both flag=0.
   - DIVU with B=0 → 0xFFFFFFFF, flag=1.
   - Without the macro, op 1010 → out=0, flag=1, latency 1.
5. Back-pressure: hold out_ready=0 for 5 cycles after out_valid, while driving in_valid=1 with new operands.
   - out/flag stay stable and in_ready stays 0; the new op is not accepted until the cycle after out_ready=1.
6. Reset: assert rst for one cycle on the 10th CALC cycle of a MULU.
   - Next cycle: out_valid=0, in_ready=1, out=0, flag=0.
   - A following ADD 105+106 completes with out=211.
